// File: rtl/md_unit_param.sv
// Parametrised HI/LO multiply/divide unit for the Ex stage.
// Result is computed at launch and committed to hi/lo after a fixed busy window.
module md_unit_param #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             wrHi,
  input  logic             wrLo,
  input  logic [WIDTH-1:0] wrData,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state | meaning
  // IDLE  | no op in flight; MTHI/MTLO accepted
  // RUN   | op in flight; counter running down to commit
  typedef enum logic {IDLE, RUN} state_t;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int W2   = 2 * WIDTH;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pendHi;
  logic [WIDTH-1:0] pendLo;
  logic             divZero;

  logic             isSigned;
  logic             isDiv;
  logic             isAcc;
  logic             isSub;
  logic [W2-1:0]    extA;
  logic [W2-1:0]    extB;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    macRes;
  logic [WIDTH:0]   divA;
  logic [WIDTH:0]   divB;
  logic [WIDTH:0]   safeB;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [W2-1:0]    result;

  assign isSigned = ~op[0];
  assign isDiv    = (op[2:1] == 2'b01);
  assign isAcc    = op[2];
  assign isSub    = op[2] & op[1];

  // Sign/zero extension to 2*WIDTH makes one modular multiply serve both kinds
  assign extA   = isSigned ? {{WIDTH{srcA[WIDTH-1]}}, srcA} : {{WIDTH{1'b0}}, srcA};
  assign extB   = isSigned ? {{WIDTH{srcB[WIDTH-1]}}, srcB} : {{WIDTH{1'b0}}, srcB};
  assign prod   = extA * extB;
  assign macRes = !isAcc ? prod : (isSub ? {hi, lo} - prod : {hi, lo} + prod);

  // One extra bit keeps most-negative / -1 in range; truncation yields most-negative, rem 0
  assign divA  = isSigned ? {srcA[WIDTH-1], srcA} : {1'b0, srcA};
  assign divB  = isSigned ? {srcB[WIDTH-1], srcB} : {1'b0, srcB};
  assign safeB = (srcB == '0) ? {{WIDTH{1'b0}}, 1'b1} : divB;
  assign quot  = WIDTH'($signed(divA) / $signed(safeB));
  assign rem   = WIDTH'($signed(divA) % $signed(safeB));

  assign result = isDiv ? {rem, quot} : macRes;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pendHi  <= '0;
      pendLo  <= '0;
      divZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            state <= IDLE;
          end else if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            cnt     <= isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            pendHi  <= result[W2-1:WIDTH];
            pendLo  <= result[WIDTH-1:0];
            divZero <= isDiv && (srcB == '0);
          end else begin
            if (wrHi) hi <= wrData;
            if (wrLo) lo <= wrData;
          end
        end
        RUN: begin
          if (flush) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            pendHi  <= '0;
            pendLo  <= '0;
            divZero <= 1'b0;
          end else if (cnt == CW'(1)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            divZero <= 1'b0;
            if (!divZero) begin
              hi <= pendHi;
              lo <= pendLo;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_param.sv
// Randomised bench for md_unit_param with an arithmetic HI/LO reference model.
// A second small instance covers the narrow-width, single-cycle configuration.
module tb_md_unit_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start, wrHi, wrLo, flush, busy;
  logic [2:0]  op;
  logic [31:0] srcA, srcB, wrData, hi, lo;

  logic       start8, wrHi8, wrLo8, flush8, busy8;
  logic [2:0] op8;
  logic [7:0] srcA8, srcB8, wrData8, hi8, lo8;

  md_unit_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .wrHi(wrHi), .wrLo(wrLo), .wrData(wrData), .flush(flush),
    .busy(busy), .hi(hi), .lo(lo)
  );

  md_unit_param #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(2)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .srcA(srcA8), .srcB(srcB8),
    .wrHi(wrHi8), .wrLo(wrLo8), .wrData(wrData8), .flush(flush8),
    .busy(busy8), .hi(hi8), .lo(lo8)
  );

  int nVec = 0;
  int nErr = 0;
  logic [31:0] mHi, mLo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: HI/LO as one 64-bit accumulator, integer division with explicit edge cases
  task automatic modelOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int cyc);
    logic [63:0] acc, p;
    int sa, sb;
    sa  = a;
    sb  = b;
    acc = {mHi, mLo};
    if (o == 3'd2 || o == 3'd3) begin
      cyc = 10;
      if (b != 0) begin
        if (o == 3'd3) begin
          mLo = a / b;
          mHi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          mLo = a;
          mHi = 0;
        end else begin
          mLo = sa / sb;
          mHi = sa % sb;
        end
      end
    end else begin
      cyc = 5;
      if (o[0]) p = {32'b0, a} * {32'b0, b};
      else      p = longint'(sa) * longint'(sb);
      if (o < 3'd4)       acc = p;
      else if (o < 3'd6)  acc = acc + p;
      else                acc = acc - p;
      {mHi, mLo} = acc;
    end
  endtask

  task automatic doOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int cyc, n;
    modelOp(o, a, b, cyc);
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); srcA = $urandom; srcB = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("busyLen op%0d", o), 64'(n), 64'(cyc));
    chk($sformatf("hi op%0d", o), {32'b0, hi}, {32'b0, mHi});
    chk($sformatf("lo op%0d", o), {32'b0, lo}, {32'b0, mLo});
  endtask

  task automatic mtReg(input bit h, input bit l, input logic [31:0] d);
    @(negedge clk);
    wrHi = h; wrLo = l; wrData = d;
    @(negedge clk);
    wrHi = 1'b0; wrLo = 1'b0;
    if (h) mHi = d;
    if (l) mLo = d;
    chk("mtHi", {32'b0, hi}, {32'b0, mHi});
    chk("mtLo", {32'b0, lo}, {32'b0, mLo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    start = 0; op = 0; srcA = 0; srcB = 0; wrHi = 0; wrLo = 0; wrData = 0; flush = 0;
    start8 = 0; op8 = 0; srcA8 = 0; srcB8 = 0; wrHi8 = 0; wrLo8 = 0; wrData8 = 0; flush8 = 0;
    mHi = 0; mLo = 0;
    #12;
    chk("rstBusy", {63'b0, busy}, 64'd0);
    chk("rstHi", {32'b0, hi}, 64'd0);
    chk("rstLo", {32'b0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    doOp(3'd0, 32'hFFFF_FFFD, 32'd7);
    chk("multConstHi", {32'b0, hi}, 64'hFFFF_FFFF);
    chk("multConstLo", {32'b0, lo}, 64'hFFFF_FFEB);
    doOp(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("divConstLo", {32'b0, lo}, 64'hFFFF_FFFD);
    chk("divConstHi", {32'b0, hi}, 64'hFFFF_FFFF);
    doOp(3'd3, 32'hFFFF_FFF9, 32'd2);
    chk("divuConstLo", {32'b0, lo}, 64'h7FFF_FFFC);
    chk("divuConstHi", {32'b0, hi}, 64'h1);

    mtReg(1'b1, 1'b0, 32'd0);
    mtReg(1'b0, 1'b1, 32'd5);
    doOp(3'd5, 32'hFFFF_FFFF, 32'd2);
    doOp(3'd6, 32'd1, 32'd4);
    doOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovfLo", {32'b0, lo}, 64'h8000_0000);
    chk("ovfHi", {32'b0, hi}, 64'h0);
    mtReg(1'b1, 1'b1, 32'hA5A5_1234);
    doOp(3'd2, 32'd123, 32'd0);

    // flush on the third busy cycle
    @(negedge clk);
    start = 1'b1; op = 3'd1; srcA = 32'd2; srcB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("flushBusy1", {63'b0, busy}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flushBusyOff", {63'b0, busy}, 64'd0);
    chk("flushHi", {32'b0, hi}, {32'b0, mHi});
    chk("flushLo", {32'b0, lo}, {32'b0, mLo});
    repeat (6) @(negedge clk);
    chk("flushStillIdle", {63'b0, busy}, 64'd0);
    chk("flushNoCommit", {32'b0, lo}, {32'b0, mLo});

    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd0; srcA = 32'd5; srcB = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("startFlushBusy", {63'b0, busy}, 64'd0);

    // reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 3'd2; srcA = 32'd100; srcB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midRstBusy", {63'b0, busy}, 64'd0);
    chk("midRstHi", {32'b0, hi}, 64'd0);
    chk("midRstLo", {32'b0, lo}, 64'd0);
    mHi = 0; mLo = 0;
    @(negedge clk);
    reset = 1'b1;
    doOp(3'd2, 32'd55, 32'd0);

    repeat (60) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 8) doOp(3'(r), pick(), pick());
      else       mtReg(1'($urandom), 1'($urandom), $urandom);
    end

    // narrow instance: 1-cycle multiply, MTHI during busy ignored
    @(negedge clk);
    start8 = 1'b1; op8 = 3'd0; srcA8 = 8'h80; srcB8 = 8'h80;
    @(negedge clk);
    start8 = 1'b0;
    chk("n8Busy", {63'b0, busy8}, 64'd1);
    wrHi8 = 1'b1; wrData8 = 8'h55;
    @(negedge clk);
    wrHi8 = 1'b0;
    chk("n8BusyOff", {63'b0, busy8}, 64'd0);
    chk("n8Hi", {56'b0, hi8}, 64'h40);
    chk("n8Lo", {56'b0, lo8}, 64'h00);
    @(negedge clk);
    start8 = 1'b1; op8 = 3'd2; srcA8 = 8'h80; srcB8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("n8DivBusyOff", {63'b0, busy8}, 64'd0);
    chk("n8DivLo", {56'b0, lo8}, 64'h80);
    chk("n8DivHi", {56'b0, hi8}, 64'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
